// File: rtl/io_pwm_led_pkg.sv
// io_pwm_led_pkg: register offsets, field positions and the CHn writable-bit mask
package io_pwm_led_pkg;
    localparam int OFF_CTRL = 0;
    localparam int OFF_STATUS = 1;
    localparam int OFF_CH0 = 2;
    localparam int CTRL_EN = 0;
    localparam int CTRL_PRE_LSB = 8;
    localparam int CH_R_LSB = 0;
    localparam int CH_G_LSB = 10;
    localparam int CH_B_LSB = 20;
    localparam int CH_BLINK = 30;
    localparam int CH_INV = 31;
    function automatic logic [31:0] ch_mask(input int cw);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < cw; i++) begin
            m[CH_R_LSB + i] = 1'b1;
            m[CH_G_LSB + i] = 1'b1;
            m[CH_B_LSB + i] = 1'b1;
        end
        m[CH_BLINK] = 1'b1;
        m[CH_INV] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/io_pwm_led_pwm_channel.sv
// io_pwm_led_pwm_channel: frame-shadowed duties, comparators, blink/invert and output flops for one RGB LED
module io_pwm_led_pwm_channel #(
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0][CW-1:0]   duty,
    input  logic                 blink,
    input  logic                 inv,
    input  logic [CW-1:0]        pwm_cnt,
    input  logic                 wrap,
    input  logic                 en,
    input  logic                 blink_ph,
    output logic [2:0]           rgb
);
    logic [2:0][CW-1:0] duty_q;
    logic blink_q, inv_q;
    logic [2:0] on;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            blink_q <= 1'b0;
            inv_q <= 1'b0;
        end else if (wrap || !en) begin
            duty_q <= duty;
            blink_q <= blink;
            inv_q <= inv;
        end
    end
    for (genvar c = 0; c < 3; c++) begin : g_col
        assign on[c] = en && (&duty_q[c] || pwm_cnt < duty_q[c]) && !(blink_q && blink_ph);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb <= '0;
        else rgb <= on ^ {3{inv_q}};
    end
endmodule

// File: rtl/io_pwm_led.sv
// io_pwm_led: NCH-channel RGB PWM LED peripheral on the dma_io bus with daisy-chained reads
module io_pwm_led
    import io_pwm_led_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          CW        = 8,
    parameter logic [13:0] BASE_ADR  = 14'h3E00,
    parameter int          BLINK_BIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dma_io_we,
    input  logic [13:0]      dma_io_wadr,
    input  logic [31:0]      dma_io_wdata,
    input  logic [13:0]      dma_io_radr,
    input  logic             dma_io_radr_en,
    input  logic [31:0]      dma_io_rdata_in,
    output logic [31:0]      dma_io_rdata,
    output logic [3*NCH-1:0] rgb_led
);
    localparam logic [31:0] CMASK = ch_mask(CW);
    localparam logic [13:0] LAST = BASE_ADR + 14'(NCH + 1);
    logic en_q, hit_q, wr_hit, rd_hit, ctrl_wr, tick, wrap;
    logic [7:0] pre_q, pre_cnt;
    logic [31:0] ch_q [NCH];
    logic [CW-1:0] pwm_cnt;
    logic [15:0] frame_cnt;
    logic [13:0] woff, roff;
    logic [31:0] rval, rdata_q;
    assign woff = dma_io_wadr - BASE_ADR;
    assign roff = dma_io_radr - BASE_ADR;
    assign wr_hit = dma_io_we && dma_io_wadr >= BASE_ADR && dma_io_wadr <= LAST;
    assign rd_hit = dma_io_radr_en && dma_io_radr >= BASE_ADR && dma_io_radr <= LAST;
    assign ctrl_wr = wr_hit && woff == 14'(OFF_CTRL);
    assign tick = en_q && pre_cnt == pre_q;
    assign wrap = tick && &pwm_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
            pre_q <= '0;
            for (int i = 0; i < NCH; i++) ch_q[i] <= '0;
        end else if (wr_hit) begin
            if (ctrl_wr) {pre_q, en_q} <= {dma_io_wdata[CTRL_PRE_LSB +: 8], dma_io_wdata[CTRL_EN]};
            for (int i = 0; i < NCH; i++)
                if (woff == 14'(OFF_CH0 + i)) ch_q[i] <= dma_io_wdata & CMASK;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            pre_cnt <= (ctrl_wr || !en_q || tick) ? '0 : pre_cnt + 8'd1;
            pwm_cnt <= !en_q ? '0 : pwm_cnt + CW'(tick);
            frame_cnt <= frame_cnt + 16'(wrap);
        end
    end
    always_comb begin
        rval = '0;
        if (roff == 14'(OFF_CTRL)) rval = {16'b0, pre_q, 7'b0, en_q};
        if (roff == 14'(OFF_STATUS)) rval = {frame_cnt, {(16 - CW){1'b0}}, pwm_cnt};
        for (int i = 0; i < NCH; i++)
            if (roff == 14'(OFF_CH0 + i)) rval = ch_q[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            hit_q <= rd_hit;
            if (rd_hit) rdata_q <= rval;
        end
    end
    assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        io_pwm_led_pwm_channel #(.CW(CW)) u_ch (
            .clk(clk),
            .rst(rst),
            .duty({ch_q[g][CH_B_LSB +: CW], ch_q[g][CH_G_LSB +: CW], ch_q[g][CH_R_LSB +: CW]}),
            .blink(ch_q[g][CH_BLINK]),
            .inv(ch_q[g][CH_INV]),
            .pwm_cnt(pwm_cnt),
            .wrap(wrap),
            .en(en_q),
            .blink_ph(frame_cnt[BLINK_BIT]),
            .rgb(rgb_led[3*g +: 3])
        );
    end
endmodule

// File: tb/tb_io_pwm_led.sv
// tb_io_pwm_led: randomized and directed checks of io_pwm_led against a tick-counting reference model
module tb_io_pwm_led;
    localparam int NCH = 4;
    localparam int FULL = 256;
    localparam int BB = 3;
    localparam logic [13:0] BASE = 14'h3E00;
    localparam logic [31:0] MASK = 32'hC000_0000 | (32'd255 << 20) | (32'd255 << 10) | 32'd255;
    logic clk = 0, rst = 1, dma_io_we = 0, dma_io_radr_en = 0;
    logic [13:0] dma_io_wadr = '0, dma_io_radr = '0;
    logic [31:0] dma_io_wdata = '0, dma_io_rdata_in = 32'hA5A5_0001, dma_io_rdata;
    logic [3*NCH-1:0] rgb_led;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    io_pwm_led dut (
        .clk(clk), .rst(rst), .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr),
        .dma_io_wdata(dma_io_wdata), .dma_io_radr(dma_io_radr), .dma_io_radr_en(dma_io_radr_en),
        .dma_io_rdata_in(dma_io_rdata_in), .dma_io_rdata(dma_io_rdata), .rgb_led(rgb_led)
    );
    // reference: c = clocks since counting restarted, n = ticks since enable, fbase = frames banked before last disable
    int m_en, m_pre, c, n, fbase;
    logic [31:0] m_ch [NCH];
    logic [31:0] m_act [NCH];
    logic [3*NCH-1:0] m_rgb;
    logic m_hit;
    logic [31:0] m_rd;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask
    function automatic void m_reset();
        m_en = 0; m_pre = 0; c = 0; n = 0; fbase = 0; m_rgb = '0; m_hit = 0; m_rd = '0;
        for (int i = 0; i < NCH; i++) begin m_ch[i] = '0; m_act[i] = '0; end
    endfunction
    function automatic void model();
        int pwm, roff, woff, duty;
        logic [15:0] fr;
        logic tick, on;
        pwm = n % FULL;
        fr = 16'((fbase + n / FULL) % 65536);
        for (int i = 0; i < NCH; i++)
            for (int k = 0; k < 3; k++) begin
                duty = int'((m_act[i] >> (10 * k)) & 32'(FULL - 1));
                on = m_en != 0 && (duty == FULL - 1 || pwm < duty) && !(m_act[i][30] && fr[BB]);
                m_rgb[3 * i + k] = on ^ m_act[i][31];
            end
        roff = int'(dma_io_radr) - int'(BASE);
        m_hit = dma_io_radr_en && roff >= 0 && roff <= NCH + 1;
        if (m_hit) m_rd = roff == 0 ? 32'((m_pre << 8) | m_en) : roff == 1 ? {fr, 8'd0, 8'(pwm)} : m_ch[roff - 2];
        tick = m_en != 0 && (c % (m_pre + 1)) == m_pre;
        if ((tick && pwm == FULL - 1) || m_en == 0)
            for (int i = 0; i < NCH; i++) m_act[i] = m_ch[i];
        if (m_en == 0) begin
            fbase = int'(fr); n = 0; c = 0;
        end else begin
            if (tick) n++;
            c++;
        end
        woff = int'(dma_io_wadr) - int'(BASE);
        if (dma_io_we && woff == 0) begin
            m_en = int'(dma_io_wdata[0]); m_pre = int'(dma_io_wdata[15:8]); c = 0;
        end
        if (dma_io_we && woff >= 2 && woff <= NCH + 1) m_ch[woff - 2] = dma_io_wdata & MASK;
    endfunction
    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("rgb_led", 32'(rgb_led), 32'(m_rgb));
        chk("rdata", dma_io_rdata, m_hit ? m_rd : dma_io_rdata_in);
    endtask
    task automatic idle(input int k);
        repeat (k) step();
    endtask
    task automatic wr(input int off, input logic [31:0] d);
        dma_io_we = 1; dma_io_wadr = BASE + 14'(off); dma_io_wdata = d;
        step();
        dma_io_we = 0;
    endtask
    task automatic rd(input int off, output logic [31:0] v);
        dma_io_radr_en = 1; dma_io_radr = BASE + 14'(off);
        step();
        v = dma_io_rdata;
        dma_io_radr_en = 0;
    endtask
    task automatic count(input int k, input int b, output int cnt);
        cnt = 0;
        repeat (k) begin step(); cnt += int'(rgb_led[b]); end
    endtask
    initial begin
        logic [31:0] v, s1, s2;
        int cnt, off;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rgb", 32'(rgb_led), 32'd0);
        rst = 0;
        step();
        chk("passthru", dma_io_rdata, 32'hA5A5_0001);
        for (int i = 0; i < NCH + 2; i++) begin
            rd(i, v);
            chk($sformatf("reset_reg%0d", i), v, 32'd0);
        end
        wr(2, 32'h40);
        wr(0, 32'h1);
        idle(20);
        count(256, 0, cnt);
        chk("duty40_count", 32'(cnt), 32'd64);
        wr(2, 32'h0);
        idle(300);
        count(256, 0, cnt);
        chk("duty00_count", 32'(cnt), 32'd0);
        wr(2, 32'hFF);
        idle(300);
        count(256, 0, cnt);
        chk("dutyFF_count", 32'(cnt), 32'd256);
        wr(2, 32'h40);
        idle(400);
        wr(2, 32'hC0);
        idle(600);
        count(256, 0, cnt);
        chk("dutyC0_count", 32'(cnt), 32'd192);
        wr(0, 32'h301);
        idle(50);
        rd(1, s1);
        idle(1023);
        rd(1, s2);
        chk("pre3_frame_step", 32'(s2[31:16] - s1[31:16]), 32'd1);
        chk("pre3_pwm_same", 32'(s2[7:0]), 32'(s1[7:0]));
        idle(2);
        wr(0, 32'h301);
        idle(30);
        wr(1, 32'hFFFF_FFFF);
        wr(NCH + 2, 32'hFFFF_FFFF);
        for (int i = 0; i < NCH + 2; i++) rd(i, v);
        wr(2, 32'h11);
        dma_io_radr_en = 1; dma_io_radr = BASE + 14'd2;
        dma_io_we = 1; dma_io_wadr = BASE + 14'd2; dma_io_wdata = 32'h22;
        step();
        chk("rw_same_old", dma_io_rdata, 32'h11);
        dma_io_we = 0; dma_io_radr_en = 0;
        rd(2, v);
        chk("rw_next_new", v, 32'h22);
        repeat (3000) begin
            dma_io_rdata_in = $urandom;
            dma_io_radr_en = $urandom_range(0, 3) == 0;
            dma_io_radr = BASE + 14'($urandom_range(0, NCH + 3));
            dma_io_we = $urandom_range(0, 9) == 0;
            off = $urandom_range(0, NCH + 3);
            dma_io_wadr = BASE + 14'(off);
            dma_io_wdata = off == 0 ? {16'd0, 8'($urandom_range(0, 3)), 7'd0, 1'($urandom_range(0, 7) != 0)} : $urandom;
            step();
        end
        dma_io_we = 0; dma_io_radr_en = 0; dma_io_rdata_in = 32'hA5A5_0001;
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("async_rst_rgb", 32'(rgb_led), 32'd0);
        chk("async_rst_rdata", dma_io_rdata, 32'hA5A5_0001);
        m_reset();
        @(posedge clk);
        #1;
        rst = 0;
        wr(3, 32'h4FF3_FCFF);
        wr(0, 32'h1);
        idle(100);
        chk("blink_frame0", 32'(rgb_led[5:3]), 32'd7);
        idle(8 * 256);
        chk("blink_frame8", 32'(rgb_led[5:3]), 32'd0);
        idle(8 * 256);
        chk("blink_frame16", 32'(rgb_led[5:3]), 32'd7);
        wr(3, 32'h8000_0000);
        wr(0, 32'h0);
        idle(3);
        chk("inv_disabled", 32'(rgb_led[5:3]), 32'd7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
